// File: rtl/mem_bus_ctrl.sv
// MEM-stage data bus controller: latches one load/store, runs the bus req/resp handshake.
// Optional WAIT timeout abort when MEM_BUS_TIMEOUT_EN is defined.
module mem_bus_ctrl #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_wen,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wmask,
    output logic        stall,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_req_wen,
    output logic [63:0] bus_addr,
    output logic [63:0] bus_wdata,
    output logic [7:0]  bus_wstrb,
    input  logic        bus_resp_valid,
    input  logic [63:0] bus_resp_rdata,
    input  logic        bus_resp_err
);

    if ((1 << CNT_W) <= TIMEOUT_CYCLES) begin : g_bad_cfg
        $error("mem_bus_ctrl: CNT_W too narrow for TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

    state_e      state_q, state_d;
    logic        bus_req_valid_q, bus_req_valid_d;
    logic        wen_q, wen_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  wstrb_q, wstrb_d;
    logic        resp_valid_q, resp_valid_d;
    logic [63:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic        flush_q, flush_d;
    logic        flushed;
`ifdef MEM_BUS_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    always_comb begin
        state_d         = state_q;
        bus_req_valid_d = 1'b0;
        wen_d           = wen_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        wstrb_d         = wstrb_q;
        resp_valid_d    = 1'b0;
        resp_rdata_d    = resp_rdata_q;
        resp_err_d      = resp_err_q;
        flush_d         = flush_q;
        // A flushed access still completes on the bus but reports no completion.
        flushed         = flush_q | ~req_valid;
`ifdef MEM_BUS_TIMEOUT_EN
        cnt_d           = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    wen_d   = req_wen;
                    addr_d  = {req_addr[63:3], 3'b000};
                    wdata_d = req_wdata << {req_addr[2:0], 3'b000};
                    wstrb_d = req_wen ? req_wmask : 8'h00;
                    flush_d = 1'b0;
                    if (req_wen && req_wmask == 8'h00) begin
                        state_d      = S_DONE;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = '0;
                        resp_err_d   = 1'b0;
                    end else begin
                        state_d         = S_REQ;
                        bus_req_valid_d = 1'b1;
                    end
                end
            end
            S_REQ: begin
                flush_d = flushed;
                if (bus_req_ready) begin
                    state_d = S_WAIT;
`ifdef MEM_BUS_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else begin
                    bus_req_valid_d = 1'b1;
                end
            end
            S_WAIT: begin
                flush_d = flushed;
                if (bus_resp_valid) begin
                    state_d      = S_DONE;
                    resp_valid_d = ~flushed;
                    resp_rdata_d = wen_q ? 64'h0 : bus_resp_rdata;
                    resp_err_d   = bus_resp_err;
                end
`ifdef MEM_BUS_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == TO_LIM) begin
                        state_d      = S_DONE;
                        resp_valid_d = ~flushed;
                        resp_rdata_d = '0;
                        resp_err_d   = 1'b1;
                    end
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            bus_req_valid_q <= 1'b0;
            wen_q           <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            wstrb_q         <= '0;
            resp_valid_q    <= 1'b0;
            resp_rdata_q    <= '0;
            resp_err_q      <= 1'b0;
            flush_q         <= 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
            cnt_q           <= '0;
`endif
        end else begin
            state_q         <= state_d;
            bus_req_valid_q <= bus_req_valid_d;
            wen_q           <= wen_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            wstrb_q         <= wstrb_d;
            resp_valid_q    <= resp_valid_d;
            resp_rdata_q    <= resp_rdata_d;
            resp_err_q      <= resp_err_d;
            flush_q         <= flush_d;
`ifdef MEM_BUS_TIMEOUT_EN
            cnt_q           <= cnt_d;
`endif
        end
    end

    assign stall         = req_valid & (state_q != S_DONE);
    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = resp_rdata_q;
    assign resp_err      = resp_err_q;
    assign bus_req_valid = bus_req_valid_q;
    assign bus_req_wen   = wen_q;
    assign bus_addr      = addr_q;
    assign bus_wdata     = wdata_q;
    assign bus_wstrb     = wstrb_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl; expected values hand-computed per step.
module tb_mem_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_wen;
    logic [63:0] req_addr, req_wdata;
    logic [7:0]  req_wmask;
    logic        stall, resp_valid, resp_err;
    logic [63:0] resp_rdata;
    logic        bus_req_valid, bus_req_ready, bus_req_wen;
    logic [63:0] bus_addr, bus_wdata;
    logic [7:0]  bus_wstrb;
    logic        bus_resp_valid, bus_resp_err;
    logic [63:0] bus_resp_rdata;

    int n_cmp = 0;
    int n_err = 0;

    mem_bus_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_wen(req_wen), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wmask(req_wmask),
        .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_wen(bus_req_wen),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_resp_valid(bus_resp_valid), .bus_resp_rdata(bus_resp_rdata), .bus_resp_err(bus_resp_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wen, input logic [63:0] addr, input logic [63:0] wd,
                         input logic [7:0] mask);
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wd;
        req_wmask = mask;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_resp_valid"}, 64'(resp_valid), 64'h0);
        chk({tag, "_resp_rdata"}, resp_rdata, 64'h0);
        chk({tag, "_resp_err"}, 64'(resp_err), 64'h0);
        chk({tag, "_bus_req_valid"}, 64'(bus_req_valid), 64'h0);
        chk({tag, "_bus_req_wen"}, 64'(bus_req_wen), 64'h0);
        chk({tag, "_bus_addr"}, bus_addr, 64'h0);
        chk({tag, "_bus_wdata"}, bus_wdata, 64'h0);
        chk({tag, "_bus_wstrb"}, 64'(bus_wstrb), 64'h0);
        chk({tag, "_stall"}, 64'(stall), 64'h0);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 0; req_wen = 0; req_addr = 0; req_wdata = 0; req_wmask = 0;
        bus_req_ready = 0; bus_resp_valid = 0; bus_resp_rdata = 0; bus_resp_err = 0;
        tick(); tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // Load, immediate ready/response; response offered in REQ must be ignored
        issue(1'b0, 64'h8000_0013, 64'h0, 8'h00);
        bus_req_ready = 1'b1;
        #1 chk("ld_c0_stall", 64'(stall), 64'h1);
        chk("ld_c0_breq", 64'(bus_req_valid), 64'h0);
        tick();
        chk("ld_c1_breq", 64'(bus_req_valid), 64'h1);
        chk("ld_c1_addr", bus_addr, 64'h8000_0010);
        chk("ld_c1_wstrb", 64'(bus_wstrb), 64'h00);
        chk("ld_c1_wen", 64'(bus_req_wen), 64'h0);
        chk("ld_c1_stall", 64'(stall), 64'h1);
        bus_resp_valid = 1'b1; bus_resp_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
        chk("ld_c2_breq", 64'(bus_req_valid), 64'h0);
        chk("ld_c2_stall", 64'(stall), 64'h1);
        chk("ld_c2_rv", 64'(resp_valid), 64'h0);
        bus_resp_rdata = 64'h1122_3344_5566_7788;
        tick();
        chk("ld_c3_rv", 64'(resp_valid), 64'h1);
        chk("ld_c3_rdata", resp_rdata, 64'h1122_3344_5566_7788);
        chk("ld_c3_err", 64'(resp_err), 64'h0);
        chk("ld_c3_stall", 64'(stall), 64'h0);
        req_valid = 1'b0; bus_resp_valid = 1'b0;
        tick();
        chk("ld_c4_rv", 64'(resp_valid), 64'h0);
        chk("ld_c4_hold", resp_rdata, 64'h1122_3344_5566_7788);

        // Halfword store in the top lane; read data must come back as 0
        issue(1'b1, 64'h8000_0006, 64'hABCD, 8'hC0);
        tick();
        chk("st_c1_breq", 64'(bus_req_valid), 64'h1);
        chk("st_c1_addr", bus_addr, 64'h8000_0000);
        chk("st_c1_wdata", bus_wdata, 64'hABCD_0000_0000_0000);
        chk("st_c1_wstrb", 64'(bus_wstrb), 64'hC0);
        chk("st_c1_wen", 64'(bus_req_wen), 64'h1);
        tick();
        bus_resp_valid = 1'b1; bus_resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        chk("st_c3_rv", 64'(resp_valid), 64'h1);
        chk("st_c3_rdata", resp_rdata, 64'h0);
        req_valid = 1'b0; bus_resp_valid = 1'b0;
        tick();

        // Backpressure: ready low for 5 cycles
        bus_req_ready = 1'b0;
        issue(1'b1, 64'h0000_0101, 64'h12, 8'h02);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk($sformatf("bp_c%0d_breq", i), 64'(bus_req_valid), 64'h1);
            chk($sformatf("bp_c%0d_addr", i), bus_addr, 64'h100);
            chk($sformatf("bp_c%0d_wdata", i), bus_wdata, 64'h1200);
            chk($sformatf("bp_c%0d_wstrb", i), 64'(bus_wstrb), 64'h02);
            chk($sformatf("bp_c%0d_stall", i), 64'(stall), 64'h1);
        end
        bus_req_ready = 1'b1;
        tick();
        chk("bp_c6_breq", 64'(bus_req_valid), 64'h0);
        chk("bp_c6_rv", 64'(resp_valid), 64'h0);
        bus_resp_valid = 1'b1; bus_resp_rdata = 64'h0;
        tick();
        chk("bp_c7_rv", 64'(resp_valid), 64'h1);
        req_valid = 1'b0; bus_resp_valid = 1'b0;
        tick();

        // Bus error on a load
        issue(1'b0, 64'h0000_0040, 64'h0, 8'h00);
        tick(); tick();
        bus_resp_valid = 1'b1; bus_resp_rdata = 64'h77; bus_resp_err = 1'b1;
        tick();
        chk("err_rv", 64'(resp_valid), 64'h1);
        chk("err_err", 64'(resp_err), 64'h1);
        chk("err_rdata", resp_rdata, 64'h77);
        req_valid = 1'b0; bus_resp_valid = 1'b0; bus_resp_err = 1'b0;
        tick();

        // Zero-mask store bypasses the bus
        issue(1'b1, 64'h0000_0200, 64'h5A, 8'h00);
        #1 chk("zm_c0_stall", 64'(stall), 64'h1);
        tick();
        chk("zm_c1_rv", 64'(resp_valid), 64'h1);
        chk("zm_c1_breq", 64'(bus_req_valid), 64'h0);
        chk("zm_c1_err", 64'(resp_err), 64'h0);
        chk("zm_c1_rdata", resp_rdata, 64'h0);
        chk("zm_c1_stall", 64'(stall), 64'h0);
        req_valid = 1'b0;
        tick();
        chk("zm_c2_breq", 64'(bus_req_valid), 64'h0);

        // Flush during REQ: bus access completes, completion pulse suppressed
        issue(1'b0, 64'h0000_0300, 64'h0, 8'h00);
        tick();
        req_valid = 1'b0;
        tick();
        bus_resp_valid = 1'b1; bus_resp_rdata = 64'h99;
        tick();
        chk("fl_rv", 64'(resp_valid), 64'h0);
        chk("fl_rdata", resp_rdata, 64'h99);
        bus_resp_valid = 1'b0;
        tick();
        chk("fl_idle_rv", 64'(resp_valid), 64'h0);

        // Reset while in WAIT, then a stale response in IDLE
        issue(1'b0, 64'h0000_0408, 64'h0, 8'h00);
        tick(); tick();
        rst = 1'b1; req_valid = 1'b0;
        tick();
        chk_all_zero("rstw");
        rst = 1'b0;
        bus_resp_valid = 1'b1; bus_resp_rdata = 64'hCAFE; bus_resp_err = 1'b1;
        tick(); tick();
        chk("rstw_late_rv", 64'(resp_valid), 64'h0);
        chk("rstw_late_rdata", resp_rdata, 64'h0);
        chk("rstw_late_err", 64'(resp_err), 64'h0);
        bus_resp_valid = 1'b0; bus_resp_err = 1'b0;
        tick();

        // No response in WAIT (TIMEOUT_CYCLES=4)
        issue(1'b0, 64'h0000_0500, 64'h0, 8'h00);
        tick(); tick();
        tick(); tick(); tick();
        chk("to_c5_rv", 64'(resp_valid), 64'h0);
        chk("to_c5_stall", 64'(stall), 64'h1);
        tick();
`ifdef MEM_BUS_TIMEOUT_EN
        chk("to_c6_rv", 64'(resp_valid), 64'h1);
        chk("to_c6_err", 64'(resp_err), 64'h1);
        chk("to_c6_rdata", resp_rdata, 64'h0);
        req_valid = 1'b0;
        tick();
        bus_resp_valid = 1'b1; bus_resp_rdata = 64'h1234;
        tick();
        chk("to_late_rv", 64'(resp_valid), 64'h0);
        chk("to_late_rdata", resp_rdata, 64'h0);
        bus_resp_valid = 1'b0;
`else
        chk("nto_c6_rv", 64'(resp_valid), 64'h0);
        chk("nto_c6_stall", 64'(stall), 64'h1);
        for (int i = 0; i < 6; i++) tick();
        chk("nto_c12_stall", 64'(stall), 64'h1);
        bus_resp_valid = 1'b1; bus_resp_rdata = 64'h4321;
        tick();
        chk("nto_done_rv", 64'(resp_valid), 64'h1);
        chk("nto_done_rdata", resp_rdata, 64'h4321);
        chk("nto_done_err", 64'(resp_err), 64'h0);
        req_valid = 1'b0; bus_resp_valid = 1'b0;
`endif
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
